// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station with operand snooping and lowest-index issue.
//
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global enable), need_flush_in
//   inst_*_in      : dispatch request (op, operand values/tags, destination tag)
//   full_out       : registered, every entry busy
//   alu_*_in       : ALU result broadcast (ready, value, producer tag)
//   lsb_*_in       : LSB result broadcast (ready, value, producer tag)
//   valid_out, opr1_out, opr2_out, dependency_out, alu_op_L1_out, alu_op_L2_out : issue to ALU
module alu_rs #(
    parameter int RS_SIZE_WIDTH        = 3,
    parameter int ROB_SIZE_WIDTH       = 3,
    parameter int CALC_OP_L1_NUM_WIDTH = 4
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            rdy_in,
    input  logic                            need_flush_in,
    input  logic                            inst_valid_in,
    input  logic [CALC_OP_L1_NUM_WIDTH-1:0] inst_alu_op_L1_in,
    input  logic                            inst_alu_op_L2_in,
    input  logic [31:0]                     inst_vj_in,
    input  logic [31:0]                     inst_vk_in,
    input  logic [ROB_SIZE_WIDTH:0]         inst_qj_in,
    input  logic [ROB_SIZE_WIDTH:0]         inst_qk_in,
    input  logic [ROB_SIZE_WIDTH:0]         inst_dest_in,
    output logic                            full_out,
    input  logic                            alu_ready_in,
    input  logic [31:0]                     alu_value_in,
    input  logic [ROB_SIZE_WIDTH:0]         alu_dep_in,
    input  logic                            lsb_ready_in,
    input  logic [31:0]                     lsb_value_in,
    input  logic [ROB_SIZE_WIDTH:0]         lsb_dep_in,
    output logic                            valid_out,
    output logic [31:0]                     opr1_out,
    output logic [31:0]                     opr2_out,
    output logic [ROB_SIZE_WIDTH:0]         dependency_out,
    output logic [CALC_OP_L1_NUM_WIDTH-1:0] alu_op_L1_out,
    output logic                            alu_op_L2_out
);
    localparam int N  = 1 << RS_SIZE_WIDTH;
    localparam int TW = ROB_SIZE_WIDTH + 1;
    localparam logic [TW-1:0] NONE = '1;
    typedef logic [RS_SIZE_WIDTH-1:0] idx_t;

    logic [N-1:0]                    busy_q, busy_d;
    logic [CALC_OP_L1_NUM_WIDTH-1:0] l1_q [N];
    logic [CALC_OP_L1_NUM_WIDTH-1:0] l1_d [N];
    logic                            l2_q [N];
    logic                            l2_d [N];
    logic [31:0]                     vj_q [N];
    logic [31:0]                     vj_d [N];
    logic [31:0]                     vk_q [N];
    logic [31:0]                     vk_d [N];
    logic [TW-1:0]                   qj_q [N];
    logic [TW-1:0]                   qj_d [N];
    logic [TW-1:0]                   qk_q [N];
    logic [TW-1:0]                   qk_d [N];
    logic [TW-1:0]                   dest_q [N];
    logic [TW-1:0]                   dest_d [N];

    logic                            valid_q, valid_d, full_q, full_d;
    logic [31:0]                     opr1_q, opr1_d, opr2_q, opr2_d;
    logic [TW-1:0]                   dep_q, dep_d;
    logic [CALC_OP_L1_NUM_WIDTH-1:0] op1_q, op1_d;
    logic                            op2_q, op2_d;

    logic free_found, iss_found;
    idx_t free_idx, iss_idx;

    // Resolve an operand against both broadcast buses; the ALU bus wins a tag tie.
    // A NONE tag never matches, so ready operands pass through unchanged.
    function automatic logic [TW+31:0] snoop(input logic [TW-1:0] q, input logic [31:0] v);
        return (q != NONE && alu_ready_in && q == alu_dep_in) ? {NONE, alu_value_in} :
               (q != NONE && lsb_ready_in && q == lsb_dep_in) ? {NONE, lsb_value_in} : {q, v};
    endfunction

    // Descending scan so the last hit is the lowest index.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        iss_found  = 1'b0;
        iss_idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = idx_t'(i);
            end
            if (busy_q[i] && qj_q[i] == NONE && qk_q[i] == NONE) begin
                iss_found = 1'b1;
                iss_idx   = idx_t'(i);
            end
        end
    end

    always_comb begin
        busy_d  = busy_q;
        l1_d    = l1_q;
        l2_d    = l2_q;
        vj_d    = vj_q;
        vk_d    = vk_q;
        qj_d    = qj_q;
        qk_d    = qk_q;
        dest_d  = dest_q;
        valid_d = valid_q;
        opr1_d  = opr1_q;
        opr2_d  = opr2_q;
        dep_d   = dep_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        if (need_flush_in) begin
            busy_d  = '0;
            valid_d = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                {qj_d[i], vj_d[i]} = snoop(qj_q[i], vj_q[i]);
                {qk_d[i], vk_d[i]} = snoop(qk_q[i], vk_q[i]);
            end
            valid_d = iss_found;
            if (iss_found) begin
                busy_d[iss_idx] = 1'b0;
                opr1_d          = vj_q[iss_idx];
                opr2_d          = vk_q[iss_idx];
                dep_d           = dest_q[iss_idx];
                op1_d           = l1_q[iss_idx];
                op2_d           = l2_q[iss_idx];
            end
            // free_idx comes from start-of-cycle busy, so a slot issued this edge is not reused yet.
            if (inst_valid_in && !full_q && free_found) begin
                busy_d[free_idx]                   = 1'b1;
                l1_d[free_idx]                     = inst_alu_op_L1_in;
                l2_d[free_idx]                     = inst_alu_op_L2_in;
                dest_d[free_idx]                   = inst_dest_in;
                {qj_d[free_idx], vj_d[free_idx]}   = snoop(inst_qj_in, inst_vj_in);
                {qk_d[free_idx], vk_d[free_idx]}   = snoop(inst_qk_in, inst_vk_in);
            end
        end
        full_d = &busy_d;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q  <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            opr1_q  <= '0;
            opr2_q  <= '0;
            dep_q   <= NONE;
            op1_q   <= '0;
            op2_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                l1_q[i]   <= '0;
                l2_q[i]   <= 1'b0;
                vj_q[i]   <= '0;
                vk_q[i]   <= '0;
                qj_q[i]   <= NONE;
                qk_q[i]   <= NONE;
                dest_q[i] <= NONE;
            end
        end else if (rdy_in) begin
            busy_q  <= busy_d;
            valid_q <= valid_d;
            full_q  <= full_d;
            opr1_q  <= opr1_d;
            opr2_q  <= opr2_d;
            dep_q   <= dep_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            l1_q    <= l1_d;
            l2_q    <= l2_d;
            vj_q    <= vj_d;
            vk_q    <= vk_d;
            qj_q    <= qj_d;
            qk_q    <= qk_d;
            dest_q  <= dest_d;
        end
    end

    assign full_out       = full_q;
    assign valid_out      = valid_q;
    assign opr1_out       = opr1_q;
    assign opr2_out       = opr2_q;
    assign dependency_out = dep_q;
    assign alu_op_L1_out  = op1_q;
    assign alu_op_L2_out  = op2_q;
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed bench for alu_rs with an issue scoreboard.
module tb_alu_rs;
    localparam logic [3:0] NONE = 4'hF;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  d;
        logic [3:0]  l1;
        logic        l2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, need_flush_in, inst_valid_in, inst_alu_op_L2_in;
    logic [3:0]  inst_alu_op_L1_in, inst_qj_in, inst_qk_in, inst_dest_in;
    logic [31:0] inst_vj_in, inst_vk_in;
    logic        full_out, alu_ready_in, lsb_ready_in, valid_out, alu_op_L2_out;
    logic [31:0] alu_value_in, lsb_value_in, opr1_out, opr2_out;
    logic [3:0]  alu_dep_in, lsb_dep_in, dependency_out, alu_op_L1_out;

    int   vecs = 0;
    int   errs = 0;
    exp_t sb[$];
    exp_t mon_e, mon_g;
    logic rdy_s = 1'b0;

    always #5 clk = ~clk;

    alu_rs dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .need_flush_in(need_flush_in),
        .inst_valid_in(inst_valid_in), .inst_alu_op_L1_in(inst_alu_op_L1_in),
        .inst_alu_op_L2_in(inst_alu_op_L2_in), .inst_vj_in(inst_vj_in), .inst_vk_in(inst_vk_in),
        .inst_qj_in(inst_qj_in), .inst_qk_in(inst_qk_in), .inst_dest_in(inst_dest_in),
        .full_out(full_out), .alu_ready_in(alu_ready_in), .alu_value_in(alu_value_in),
        .alu_dep_in(alu_dep_in), .lsb_ready_in(lsb_ready_in), .lsb_value_in(lsb_value_in),
        .lsb_dep_in(lsb_dep_in), .valid_out(valid_out), .opr1_out(opr1_out), .opr2_out(opr2_out),
        .dependency_out(dependency_out), .alu_op_L1_out(alu_op_L1_out), .alu_op_L2_out(alu_op_L2_out)
    );

    always @(posedge clk) rdy_s <= rdy_in;

    // Each fresh issue (not a frozen hold) must match the oldest expected issue.
    always @(negedge clk) begin
        if (valid_out && rdy_s) begin
            vecs++;
            mon_g = '{opr1_out, opr2_out, dependency_out, alu_op_L1_out, alu_op_L2_out};
            if (sb.size() == 0) begin
                errs++;
                $error("FAIL issue: unexpected issue got %h expected none", mon_g);
            end else begin
                mon_e = sb.pop_front();
                assert (mon_g === mon_e) else begin
                    errs++;
                    $error("FAIL issue: got %h expected %h", mon_g, mon_e);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        need_flush_in = 1'b0;
        inst_valid_in = 1'b0;
        alu_ready_in  = 1'b0;
        lsb_ready_in  = 1'b0;
        inst_qj_in    = NONE;
        inst_qk_in    = NONE;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic disp(input logic [3:0] l1, input logic l2, input logic [31:0] vj, input logic [31:0] vk,
                        input logic [3:0] qj, input logic [3:0] qk, input logic [3:0] dest);
        inst_valid_in     = 1'b1;
        inst_alu_op_L1_in = l1;
        inst_alu_op_L2_in = l2;
        inst_vj_in        = vj;
        inst_vk_in        = vk;
        inst_qj_in        = qj;
        inst_qk_in        = qk;
        inst_dest_in      = dest;
    endtask

    task automatic alu_bc(input logic [3:0] dep, input logic [31:0] v);
        alu_ready_in = 1'b1;
        alu_dep_in   = dep;
        alu_value_in = v;
    endtask

    task automatic lsb_bc(input logic [3:0] dep, input logic [31:0] v);
        lsb_ready_in = 1'b1;
        lsb_dep_in   = dep;
        lsb_value_in = v;
    endtask

    initial begin
        idle();
        rdy_in = 1'b1;
        inst_alu_op_L1_in = '0; inst_alu_op_L2_in = 1'b0; inst_vj_in = '0; inst_vk_in = '0;
        inst_dest_in = '0; alu_dep_in = NONE; lsb_dep_in = NONE; alu_value_in = '0; lsb_value_in = '0;
        rst_in = 1'b1;
        #12 rst_in = 1'b0;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_full", 32'(full_out), 32'd0);
        chk("rst_dep", 32'(dependency_out), 32'hF);
        chk("rst_opr1", opr1_out, 32'd0);

        // ready add: issue one edge after dispatch
        disp(4'd0, 1'b0, 32'd5, 32'd7, NONE, NONE, 4'd2);
        sb.push_back('{32'd5, 32'd7, 4'd2, 4'd0, 1'b0});
        tick(); idle();
        chk("rdy_not_yet", 32'(valid_out), 32'd0);
        tick();
        chk("rdy_issue", 32'(valid_out), 32'd1);
        tick();
        chk("rdy_done", 32'(valid_out), 32'd0);

        // wakeup of qj through the ALU bus
        disp(4'd0, 1'b1, 32'd99, 32'd3, 4'd4, NONE, 4'd3);
        tick(); idle(); ticks(2);
        chk("wait_idle", 32'(valid_out), 32'd0);
        alu_bc(4'd4, 32'd10);
        sb.push_back('{32'd10, 32'd3, 4'd3, 4'd0, 1'b1});
        tick(); idle();
        chk("wake_not_yet", 32'(valid_out), 32'd0);
        ticks(2);

        // same-cycle bypass from the LSB bus
        disp(4'd1, 1'b0, 32'd9, 32'd0, NONE, 4'd6, 4'd5);
        lsb_bc(4'd6, 32'hFFFF0000);
        sb.push_back('{32'd9, 32'hFFFF0000, 4'd5, 4'd1, 1'b0});
        tick(); idle(); ticks(2);

        // both buses carry the same tag: ALU value wins
        disp(4'd2, 1'b0, 32'd0, 32'd4, 4'd7, NONE, 4'd6);
        tick(); idle();
        alu_bc(4'd7, 32'd1);
        lsb_bc(4'd7, 32'd2);
        sb.push_back('{32'd1, 32'd4, 4'd6, 4'd2, 1'b0});
        tick(); idle(); ticks(2);

        // fill all 8 entries, 9th request dropped, drain lowest-index first
        for (int i = 0; i < 8; i++) begin
            disp(4'd3, 1'b0, 32'd0, 32'(i), 4'd1, NONE, 4'(i));
            tick();
            if (i == 6) chk("fill_7_not_full", 32'(full_out), 32'd0);
        end
        idle();
        chk("fill_full", 32'(full_out), 32'd1);
        disp(4'd3, 1'b0, 32'd55, 32'd66, NONE, NONE, 4'd8);
        tick(); idle();
        chk("drop_full", 32'(full_out), 32'd1);
        alu_bc(4'd1, 32'd100);
        for (int i = 0; i < 8; i++) sb.push_back('{32'd100, 32'(i), 4'(i), 4'd3, 1'b0});
        tick(); idle();
        chk("woken_full", 32'(full_out), 32'd1);
        tick();
        chk("drain_first_full", 32'(full_out), 32'd0);
        ticks(8);
        chk("drain_done", 32'(valid_out), 32'd0);

        // flush 4 waiting entries plus one about to issue
        for (int i = 0; i < 4; i++) begin
            disp(4'd4, 1'b0, 32'd0, 32'd0, 4'd2, NONE, 4'(10 + i));
            tick();
        end
        disp(4'd4, 1'b0, 32'd1, 32'd1, NONE, NONE, 4'd14);
        tick(); idle();
        need_flush_in = 1'b1;
        tick(); idle();
        chk("flush_valid", 32'(valid_out), 32'd0);
        chk("flush_full", 32'(full_out), 32'd0);
        alu_bc(4'd2, 32'd77);
        tick(); idle(); ticks(2);
        chk("flush_no_issue", 32'(valid_out), 32'd0);

        // rdy_in low freezes the issued outputs
        disp(4'd5, 1'b1, 32'h11, 32'h22, NONE, NONE, 4'd9);
        sb.push_back('{32'h11, 32'h22, 4'd9, 4'd5, 1'b1});
        tick(); idle(); tick();
        rdy_in = 1'b0;
        ticks(2);
        chk("frz_valid", 32'(valid_out), 32'd1);
        chk("frz_opr1", opr1_out, 32'h11);
        rdy_in = 1'b1;
        tick();
        chk("thaw_valid", 32'(valid_out), 32'd0);

        // asynchronous reset with waiting entries
        for (int i = 0; i < 3; i++) begin
            disp(4'd6, 1'b0, 32'd0, 32'd0, 4'd3, NONE, 4'(i));
            tick();
        end
        idle();
        @(negedge clk);
        #1 rst_in = 1'b1;
        #1;
        chk("arst_dep", 32'(dependency_out), 32'hF);
        chk("arst_opr1", opr1_out, 32'd0);
        chk("arst_opr2", opr2_out, 32'd0);
        chk("arst_l1", 32'(alu_op_L1_out), 32'd0);
        chk("arst_l2", 32'(alu_op_L2_out), 32'd0);
        rst_in = 1'b0;
        tick();
        alu_bc(4'd3, 32'd5);
        tick(); idle(); ticks(2);
        chk("arst_no_issue", 32'(valid_out), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
